// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-8 word distributor.
package demux_pkg;

   localparam int unsigned NCH    = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [NCH-1:0]    onehot_t;

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when en is low.
module decoder3to8
   import demux_pkg::*;
(
   input  logic    C2,
   input  logic    C1,
   input  logic    C0,
   input  logic    en,
   output onehot_t y
);

   // Exactly one output high for an enabled select, none otherwise.
   always_comb begin
      y = '0;
      if (en) begin
         y[{C2, C1, C0}] = 1'b1;
      end
   end

endmodule

// File: rtl/demux1to8b32_reg.sv
// Registered 1-to-8 word distributor with per-channel full/ack handshake.
// Optional feature: define DEMUX_OVERWRITE_EN to make in_ready constant 1 and
// let writes to a full channel overwrite it, raising the sticky ovf flag.
module demux1to8b32_reg
   import demux_pkg::*;
#(
   parameter int unsigned     WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             C2,
   input  logic             C1,
   input  logic             C0,
   input  logic [WIDTH-1:0] I,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NCH-1:0]   ack,
   output logic [WIDTH-1:0] O0,
   output logic [WIDTH-1:0] O1,
   output logic [WIDTH-1:0] O2,
   output logic [WIDTH-1:0] O3,
   output logic [WIDTH-1:0] O4,
   output logic [WIDTH-1:0] O5,
   output logic [WIDTH-1:0] O6,
   output logic [WIDTH-1:0] O7,
   output logic [NCH-1:0]   full,
   output logic             ovf
);

   logic [SEL_W-1:0] sel;
   logic             accept;
   onehot_t          we;
   onehot_t          full_q;
   logic [WIDTH-1:0] o_q [NCH];

   assign sel = {C2, C1, C0};

`ifdef DEMUX_OVERWRITE_EN
   assign in_ready = 1'b1;
`else
   // A same-cycle ack frees the slot, so a full channel can still accept.
   assign in_ready = ~full_q[sel] | ack[sel];
`endif

   assign accept = in_valid & in_ready;

   decoder3to8 u_dec (
      .C2 (C2),
      .C1 (C1),
      .C0 (C0),
      .en (accept),
      .y  (we)
   );

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [WIDTH-1:0] o_d;
      logic             full_d;

      // Write wins over ack; ack only clears full, the data is kept.
      always_comb begin
         o_d    = o_q[k];
         full_d = full_q[k];
         if (we[k]) begin
            o_d    = I;
            full_d = 1'b1;
         end else if (ack[k]) begin
            full_d = 1'b0;
         end
      end

      // Channel holding register and full bit.
      always_ff @(posedge clk) begin
         if (reset) begin
            o_q[k]    <= RESET_VAL;
            full_q[k] <= 1'b0;
         end else begin
            o_q[k]    <= o_d;
            full_q[k] <= full_d;
         end
      end
   end

`ifdef DEMUX_OVERWRITE_EN
   logic ovf_q;
   logic ovf_d;

   // Sticky: set when a full channel is written without being acked.
   always_comb begin
      ovf_d = ovf_q | (accept & full_q[sel] & ~ack[sel]);
   end

   // Overwrite flag register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign full = full_q;
   assign O0   = o_q[0];
   assign O1   = o_q[1];
   assign O2   = o_q[2];
   assign O3   = o_q[3];
   assign O4   = o_q[4];
   assign O5   = o_q[5];
   assign O6   = o_q[6];
   assign O7   = o_q[7];

endmodule

// File: tb/tb_demux1to8b32_reg.sv
// Directed self-checking bench for demux1to8b32_reg.
module tb_demux1to8b32_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  sel;
   logic [31:0] din;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  ack;
   logic [31:0] o [8];
   logic [7:0]  full;
   logic        ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   demux1to8b32_reg #(
      .WIDTH     (32),
      .RESET_VAL (32'h0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .C2       (sel[2]),
      .C1       (sel[1]),
      .C0       (sel[0]),
      .I        (din),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ack      (ack),
      .O0       (o[0]),
      .O1       (o[1]),
      .O2       (o[2]),
      .O3       (o[3]),
      .O4       (o[4]),
      .O5       (o[5]),
      .O6       (o[6]),
      .O7       (o[7]),
      .full     (full),
      .ovf      (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past a rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held two cycles while a word is offered: it must be dropped.
      reset    = 1'b1;
      in_valid = 1'b1;
      din      = 32'hDEADBEEF;
      sel      = 3'd5;
      ack      = 8'h00;
      tick();
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) check($sformatf("reset_O%0d", k), o[k], 32'h0);
      check("reset_full", {24'h0, full}, 32'h00);
      check("reset_ovf", {31'h0, ovf}, 32'h0);

      // Fill and drain channel 2.
      sel      = 3'd2;
      din      = 32'h15;
      in_valid = 1'b1;
      #1;
      check("fill_ready", {31'h0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0;
      check("fill_O2", o[2], 32'h15);
      check("fill_full", {24'h0, full}, 32'h04);
      ack = 8'h04;
      tick();
      ack = 8'h00;
      check("drain_full", {24'h0, full}, 32'h00);
      check("drain_O2_kept", o[2], 32'h15);

      // Backpressure on channel 3.
      sel      = 3'd3;
      din      = 32'h30;
      in_valid = 1'b1;
      tick();
      din = 32'h3F;
      #1;
`ifdef DEMUX_OVERWRITE_EN
      check("bp_ready", {31'h0, in_ready}, 32'h1);
      tick();
      check("bp_O3", o[3], 32'h3F);
      check("bp_ovf", {31'h0, ovf}, 32'h1);
`else
      check("bp_ready", {31'h0, in_ready}, 32'h0);
      tick();
      check("bp_O3_held", o[3], 32'h30);
      check("bp_ovf", {31'h0, ovf}, 32'h0);
`endif
      ack = 8'h08;
      #1;
      check("bp_ack_ready", {31'h0, in_ready}, 32'h1);
      tick();
      ack      = 8'h00;
      in_valid = 1'b0;
      check("bp_O3_new", o[3], 32'h3F);
      check("bp_full", {24'h0, full}, 32'h08);
      ack = 8'h08;
      tick();
      ack = 8'h00;
      check("bp_drain", {24'h0, full}, 32'h00);

      // Zero-bubble streaming into channel 7 with ack held.
      sel      = 3'd7;
      ack      = 8'h80;
      in_valid = 1'b1;
      for (int w = 1; w <= 8; w++) begin
         din = 32'(w);
         #1;
         check($sformatf("stream_ready%0d", w), {31'h0, in_ready}, 32'h1);
         tick();
         check($sformatf("stream_O7_%0d", w), o[7], 32'(w));
         check($sformatf("stream_full%0d", w), {31'h0, full[7]}, 32'h1);
      end
      in_valid = 1'b0;
      tick();
      ack = 8'h00;
      check("stream_drain", {24'h0, full}, 32'h00);

      // Independence of all eight channels.
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         din = 32'h10 * k;
         tick();
      end
      in_valid = 1'b0;
      check("ind_full_all", {24'h0, full}, 32'hFF);
      ack = 8'hAA;
      tick();
      ack = 8'h00;
      check("ind_full_55", {24'h0, full}, 32'h55);
      for (int k = 0; k < 8; k++) check($sformatf("ind_O%0d", k), o[k], 32'h10 * k);
      ack = 8'hAA;
      tick();
      ack = 8'h00;
      check("ind_empty_ack", {24'h0, full}, 32'h55);

      // in_valid low must not write.
      sel = 3'd1;
      din = 32'hFFFF;
      tick();
      check("novalid_O1", o[1], 32'h10);
      check("novalid_full", {24'h0, full}, 32'h55);

      // Second write to a full channel 4 without ack.
      ack = 8'h55;
      tick();
      ack      = 8'h00;
      sel      = 3'd4;
      din      = 32'h1;
      in_valid = 1'b1;
      tick();
      din = 32'h2;
      #1;
`ifdef DEMUX_OVERWRITE_EN
      tick();
      check("ovw_O4", o[4], 32'h2);
      check("ovw_ovf", {31'h0, ovf}, 32'h1);
`else
      check("ovw_ready", {31'h0, in_ready}, 32'h0);
      tick();
      check("ovw_O4_held", o[4], 32'h1);
      check("ovw_ovf", {31'h0, ovf}, 32'h0);
`endif
      check("ovw_full", {24'h0, full}, 32'h10);

      // Mid-operation reset clears everything and drops the offered word.
      reset = 1'b1;
      ack   = 8'h10;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      ack      = 8'h00;
      #1;
      check("rst2_full", {24'h0, full}, 32'h00);
      check("rst2_O4", o[4], 32'h0);
      check("rst2_O7", o[7], 32'h0);
      check("rst2_ovf", {31'h0, ovf}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
